// File: rtl/config_loader_pkg.sv
// Shared types and helpers for the configuration loader: FSM encoding, beat count, CRC-8 step.
package config_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic int nbeats(input int cfg_w, input int din_w);
    return (cfg_w + din_w - 1) / din_w;
  endfunction

  // One serial CRC-8 step, MSB-first register, no reflection.
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/config_loader_crc8.sv
// Parallel CRC-8 over one DIN_W-bit beat per enable, bit 0 of the beat consumed first.
module config_loader_crc8
  import config_loader_pkg::*;
#(
  parameter int DIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [7:0]       crc
);

  logic [7:0] crc_next;

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < DIN_W; i++) begin
      crc_next = crc8_bit(crc_next, din[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Assembles a byte-beat config stream and commits it atomically to cfg_out.
// Optional trailing CRC-8 beat when CONFIG_LOADER_CRC_EN is defined.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CFG_W = 212,
  parameter int DIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_valid,
  output logic             busy,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam int NBEATS = nbeats(CFG_W, DIN_W);
  localparam int CNT_W  = $clog2(NBEATS + 1);

  // Handshake: a beat transfers on a posedge where din_valid and din_ready are both high;
  // din_ready depends only on the state register, never on din_valid.
  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CFG_W-1:0] staging;
  logic [CFG_W-1:0] staging_wr;
  logic             accept;
  logic             restart;
  logic             last_beat;

  assign din_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
  assign accept    = din_valid && din_ready;
  assign restart   = start && (state != ST_COMMIT);
  assign last_beat = (beat_cnt == CNT_W'(NBEATS - 1));

  // Pad bits beyond CFG_W in the final beat simply have no destination.
  always_comb begin
    staging_wr = staging;
    for (int j = 0; j < CFG_W; j++) begin
      if (beat_cnt == CNT_W'(j / DIN_W)) staging_wr[j] = din[j % DIN_W];
    end
  end

`ifdef CONFIG_LOADER_CRC_EN
  logic [7:0] crc;
  logic       err_q;
  logic       crc_ok;

  config_loader_crc8 #(.DIN_W(DIN_W)) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .en    (accept && !restart && (state == ST_LOAD)),
    .din   (din),
    .crc   (crc)
  );

  assign crc_ok = (din[7:0] == crc);
  assign err    = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      staging   <= '0;
      cfg_out   <= '0;
      cfg_valid <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
      err_q     <= 1'b0;
`endif
    end else begin
      cfg_valid <= 1'b0;
      if (restart) begin
        state    <= ST_LOAD;
        beat_cnt <= '0;
        staging  <= '0;
`ifdef CONFIG_LOADER_CRC_EN
        err_q    <= 1'b0;
`endif
      end else begin
        case (state)
          ST_LOAD: begin
            if (accept) begin
              staging <= staging_wr;
              if (last_beat) begin
                beat_cnt <= '0;
`ifdef CONFIG_LOADER_CRC_EN
                state    <= ST_CHECK;
`else
                state    <= ST_COMMIT;
`endif
              end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
              end
            end
          end
          ST_CHECK: begin
`ifdef CONFIG_LOADER_CRC_EN
            if (accept) begin
              if (crc_ok) begin
                state <= ST_COMMIT;
              end else begin
                state <= ST_IDLE;
                err_q <= 1'b1;
              end
            end
`else
            state <= ST_IDLE;
`endif
          end
          ST_COMMIT: begin
            cfg_out   <= staging;
            cfg_valid <= 1'b1;
            state     <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
